csr_exu: RTL and testbench

- Execute-stage unit for Zicsr and trap instructions (CSRRW/S/C, immediate forms, ECALL, MRET) that sits directly upstream of the machine CSR file.
- Accepts one decoded instruction over a valid/ready handshake and drives the CSR file's read/write/exception ports.
- Computes the rd writeback value and any PC redirect, and hands the result downstream over a second valid/ready handshake.
- Non-pipelined: one instruction in flight.

---
 rtl/csr_exu.sv | 157 +++++++++++++++
 tb/tb_csr_exu.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_exu.sv
// Execute-stage unit for Zicsr and trap instructions (CSRRW/S/C, ECALL, MRET).
// Holds one instruction at a time and drives the machine CSR file's write and trap ports.
module csr_exu #(
   parameter int             XLEN           = 32,
   parameter logic [XLEN-1:0] MCAUSE_ECALL   = 32'd11,
   parameter logic [XLEN-1:0] MCAUSE_ILLEGAL = 32'd2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [2:0]      in_op,
   input  logic            in_use_imm,
   input  logic [4:0]      in_uimm,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [11:0]     in_csr_addr,
   input  logic [4:0]      in_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_rd,
   output logic            out_rd_wen,
   output logic [XLEN-1:0] out_rd_data,
   output logic            out_redirect,
   output logic [XLEN-1:0] out_redirect_pc,
   output logic [11:0]     csr_raddr,
   input  logic [XLEN-1:0] csr_rdata,
   output logic            csr_wen,
   output logic [11:0]     csr_waddr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            exception_en,
   output logic [XLEN-1:0] mepc_wdata,
   output logic [XLEN-1:0] mcause_wdata,
   input  logic [XLEN-1:0] mtvec_rdata,
   input  logic [XLEN-1:0] mepc_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   localparam logic [2:0] OP_CSRRW = 3'd0;
   localparam logic [2:0] OP_CSRRS = 3'd1;
   localparam logic [2:0] OP_CSRRC = 3'd2;
   localparam logic [2:0] OP_ECALL = 3'd3;
   localparam logic [2:0] OP_MRET  = 3'd4;

   state_t          state_reg, state_next;
   logic [XLEN-1:0] pc_reg, rs1_reg;
   logic [2:0]      op_reg;
   logic            use_imm_reg;
   logic [4:0]      uimm_reg, rd_reg;
   logic [11:0]     csr_addr_reg;

   logic [4:0]      out_rd_reg;
   logic            out_rd_wen_reg, out_redirect_reg;
   logic [XLEN-1:0] out_rd_data_reg, out_redirect_pc_reg;

   logic            in_exec, is_csr_op, addr_legal, is_illegal, is_trap, do_csr;
   logic [XLEN-1:0] src, wdata_calc, redirect_pc_calc;

   assign in_exec   = (state_reg == S_EXEC);
   assign is_csr_op = (op_reg < OP_ECALL);

   always_comb begin
      addr_legal = 1'b0;
      case (csr_addr_reg)
         12'h300, 12'h305, 12'h341, 12'h342: addr_legal = 1'b1;
         default:                            addr_legal = 1'b0;
      endcase
   end

   assign is_illegal = (op_reg > OP_MRET) || (is_csr_op && !addr_legal);
   assign is_trap    = is_illegal || (op_reg == OP_ECALL);
   assign do_csr     = is_csr_op && addr_legal;
   assign src        = use_imm_reg ? {{(XLEN-5){1'b0}}, uimm_reg} : rs1_reg;

   always_comb begin
      wdata_calc = src;
      case (op_reg)
         OP_CSRRS: wdata_calc = csr_rdata | src;
         OP_CSRRC: wdata_calc = csr_rdata & ~src;
         default:  wdata_calc = src;
      endcase
   end

   // Trap vectors are always direct-mode aligned, so the mode bits are masked off.
   always_comb begin
      redirect_pc_calc = '0;
      if (is_trap)
         redirect_pc_calc = mtvec_rdata & ~{{(XLEN-2){1'b0}}, 2'b11};
      else if (op_reg == OP_MRET)
         redirect_pc_calc = mepc_rdata;
   end

   // Set/clear with a zero rs1 field is a pure read and must not write the CSR.
   assign csr_wen      = in_exec && do_csr && ((op_reg == OP_CSRRW) || (uimm_reg != 5'd0));
   assign csr_raddr    = in_exec ? csr_addr_reg : 12'd0;
   assign csr_waddr    = in_exec ? csr_addr_reg : 12'd0;
   assign csr_wdata    = in_exec ? wdata_calc : '0;
   assign exception_en = in_exec && is_trap;
   assign mepc_wdata   = exception_en ? pc_reg : '0;
   assign mcause_wdata = exception_en ? (is_illegal ? MCAUSE_ILLEGAL : MCAUSE_ECALL) : '0;

   assign in_ready        = (state_reg == S_IDLE);
   assign out_valid       = (state_reg == S_RESP);
   assign out_rd          = out_rd_reg;
   assign out_rd_wen      = out_rd_wen_reg;
   assign out_rd_data     = out_rd_data_reg;
   assign out_redirect    = out_redirect_reg;
   assign out_redirect_pc = out_redirect_pc_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (in_valid) state_next = S_EXEC;
         S_EXEC:  state_next = S_RESP;
         S_RESP:  if (out_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg           <= S_IDLE;
         pc_reg              <= '0;
         rs1_reg             <= '0;
         op_reg              <= 3'd0;
         use_imm_reg         <= 1'b0;
         uimm_reg            <= 5'd0;
         rd_reg              <= 5'd0;
         csr_addr_reg        <= 12'd0;
         out_rd_reg          <= 5'd0;
         out_rd_wen_reg      <= 1'b0;
         out_rd_data_reg     <= '0;
         out_redirect_reg    <= 1'b0;
         out_redirect_pc_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_IDLE && in_valid) begin
            pc_reg       <= in_pc;
            rs1_reg      <= in_rs1_data;
            op_reg       <= in_op;
            use_imm_reg  <= in_use_imm;
            uimm_reg     <= in_uimm;
            rd_reg       <= in_rd;
            csr_addr_reg <= in_csr_addr;
         end
         if (in_exec) begin
            out_rd_reg          <= rd_reg;
            out_rd_wen_reg      <= do_csr && (rd_reg != 5'd0);
            out_rd_data_reg     <= csr_rdata;
            out_redirect_reg    <= is_trap || (op_reg == OP_MRET);
            out_redirect_pc_reg <= redirect_pc_calc;
         end
      end
   end

endmodule

// File: tb/tb_csr_exu.sv
// Bench for csr_exu: a small machine CSR file plus a transaction-level model
// of each instruction's effect, checked cycle by cycle against a timeline.
module tb_csr_exu;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid, in_ready, in_use_imm, out_valid, out_ready;
   logic [31:0] in_pc, in_rs1_data;
   logic [2:0]  in_op;
   logic [4:0]  in_uimm, in_rd, out_rd;
   logic [11:0] in_csr_addr, csr_raddr, csr_waddr;
   logic        out_rd_wen, out_redirect, csr_wen, exception_en;
   logic [31:0] out_rd_data, out_redirect_pc, csr_rdata, csr_wdata;
   logic [31:0] mepc_wdata, mcause_wdata, mtvec_rdata, mepc_rdata;

   always #5 clock = ~clock;

   csr_exu dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_op(in_op),
      .in_use_imm(in_use_imm), .in_uimm(in_uimm), .in_rs1_data(in_rs1_data),
      .in_csr_addr(in_csr_addr), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
      .out_rd_wen(out_rd_wen), .out_rd_data(out_rd_data),
      .out_redirect(out_redirect), .out_redirect_pc(out_redirect_pc),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_wen(csr_wen),
      .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .exception_en(exception_en),
      .mepc_wdata(mepc_wdata), .mcause_wdata(mcause_wdata),
      .mtvec_rdata(mtvec_rdata), .mepc_rdata(mepc_rdata)
   );

   // Machine CSR file seen by the unit
   logic [31:0] mstatus_m = 32'h1800;
   logic [31:0] mtvec_m   = 32'h0;
   logic [31:0] mepc_m    = 32'h0;
   logic [31:0] mcause_m  = 32'h0;
   int          wen_count = 0;

   assign mtvec_rdata = mtvec_m;
   assign mepc_rdata  = mepc_m;

   always_comb begin
      csr_rdata = 32'h0;
      case (csr_raddr)
         12'h300: csr_rdata = mstatus_m;
         12'h305: csr_rdata = mtvec_m;
         12'h341: csr_rdata = mepc_m;
         12'h342: csr_rdata = mcause_m;
         default: csr_rdata = 32'h0;
      endcase
   end

   always @(posedge clock) begin
      if (exception_en) begin
         mepc_m   <= mepc_wdata;
         mcause_m <= mcause_wdata;
      end
      if (csr_wen) begin
         wen_count <= wen_count + 1;
         case (csr_waddr)
            12'h300: mstatus_m <= csr_wdata;
            12'h305: mtvec_m   <= csr_wdata;
            12'h341: mepc_m    <= csr_wdata;
            12'h342: mcause_m  <= csr_wdata;
            default: ;
         endcase
      end
   end

   // Transaction model
   typedef struct {
      logic        wen;
      logic [31:0] wdata;
      logic [11:0] addr;
      logic        exc;
      logic [31:0] mepc;
      logic [31:0] cause;
      logic        rd_wen;
      logic [4:0]  rd;
      logic [31:0] rd_data;
      logic        redir;
      logic [31:0] rpc;
   } exp_t;

   exp_t exp_q;

   function automatic logic [31:0] csr_read(input logic [11:0] a);
      if (a == 12'h300) return mstatus_m;
      if (a == 12'h305) return mtvec_m;
      if (a == 12'h341) return mepc_m;
      if (a == 12'h342) return mcause_m;
      return 32'h0;
   endfunction

   function automatic exp_t model(input logic [2:0] op, input logic ui, input logic [4:0] uimm,
                                  input logic [31:0] rs1, input logic [11:0] addr,
                                  input logic [4:0] rd, input logic [31:0] pc);
      exp_t        e;
      logic        legal, is_csr, illegal;
      logic [31:0] src, old;
      legal   = (addr == 12'h300) || (addr == 12'h305) || (addr == 12'h341) || (addr == 12'h342);
      is_csr  = (op < 3);
      illegal = (op > 4) || (is_csr && !legal);
      src     = ui ? {27'd0, uimm} : rs1;
      old     = csr_read(addr);
      e.addr  = addr;
      e.wen   = is_csr && legal && (op == 0 || uimm != 0);
      e.wdata = (op == 0) ? src : (op == 1) ? (old | src) : (old & ~src);
      e.exc   = (op == 3) || illegal;
      e.mepc  = pc;
      e.cause = (op == 3) ? 32'd11 : 32'd2;
      e.rd_wen  = is_csr && legal && (rd != 0);
      e.rd      = rd;
      e.rd_data = old;
      e.redir   = e.exc || (op == 4);
      e.rpc     = e.exc ? {mtvec_m[31:2], 2'b00} : (op == 4) ? mepc_m : 32'h0;
      return e;
   endfunction

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, expv, $time);
      end
   endtask

   // Timeline position, advanced by the driver just after each clock edge
   localparam int P_IDLE = 0, P_EXEC = 1, P_RESP = 2;
   int phase = P_IDLE;

   always @(negedge clock) begin
      case (phase)
         P_IDLE: begin
            chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
            chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
            chk("idle_csr_wen", {31'd0, csr_wen}, 32'd0);
            chk("idle_exception_en", {31'd0, exception_en}, 32'd0);
         end
         P_EXEC: begin
            chk("exec_in_ready", {31'd0, in_ready}, 32'd0);
            chk("exec_out_valid", {31'd0, out_valid}, 32'd0);
            chk("exec_csr_raddr", {20'd0, csr_raddr}, {20'd0, exp_q.addr});
            chk("exec_csr_wen", {31'd0, csr_wen}, {31'd0, exp_q.wen});
            chk("exec_exception_en", {31'd0, exception_en}, {31'd0, exp_q.exc});
            if (exp_q.wen) begin
               chk("exec_csr_waddr", {20'd0, csr_waddr}, {20'd0, exp_q.addr});
               chk("exec_csr_wdata", csr_wdata, exp_q.wdata);
            end
            if (exp_q.exc) begin
               chk("exec_mepc_wdata", mepc_wdata, exp_q.mepc);
               chk("exec_mcause_wdata", mcause_wdata, exp_q.cause);
            end
         end
         P_RESP: begin
            chk("resp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("resp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("resp_csr_wen", {31'd0, csr_wen}, 32'd0);
            chk("resp_exception_en", {31'd0, exception_en}, 32'd0);
            chk("resp_out_rd", {27'd0, out_rd}, {27'd0, exp_q.rd});
            chk("resp_out_rd_wen", {31'd0, out_rd_wen}, {31'd0, exp_q.rd_wen});
            chk("resp_out_rd_data", out_rd_data, exp_q.rd_data);
            chk("resp_out_redirect", {31'd0, out_redirect}, {31'd0, exp_q.redir});
            chk("resp_out_redirect_pc", out_redirect_pc, exp_q.rpc);
         end
         default: ;
      endcase
   end

   logic        cap_wen, cap_exc, cap_rd_wen, cap_redir;
   logic [31:0] cap_wdata, cap_mepc, cap_mcause, cap_rd_data, cap_rpc;

   task automatic run_op(input logic [2:0] op, input logic ui, input logic [4:0] uimm,
                         input logic [31:0] rs1, input logic [11:0] addr,
                         input logic [4:0] rd, input logic [31:0] pc, input int stall);
      @(negedge clock);
      exp_q       = model(op, ui, uimm, rs1, addr, rd, pc);
      in_op       = op;
      in_use_imm  = ui;
      in_uimm     = uimm;
      in_rs1_data = rs1;
      in_csr_addr = addr;
      in_rd       = rd;
      in_pc       = pc;
      in_valid    = 1'b1;
      out_ready   = (stall == 0);
      @(posedge clock); #1;
      in_valid = 1'b0;
      phase    = P_EXEC;
      @(negedge clock); #1;
      cap_wen    = csr_wen;
      cap_wdata  = csr_wdata;
      cap_exc    = exception_en;
      cap_mepc   = mepc_wdata;
      cap_mcause = mcause_wdata;
      @(posedge clock); #1;
      phase = P_RESP;
      repeat (stall) begin
         @(posedge clock); #1;
      end
      out_ready = 1'b1;
      @(negedge clock); #1;
      cap_rd_wen  = out_rd_wen;
      cap_rd_data = out_rd_data;
      cap_redir   = out_redirect;
      cap_rpc     = out_redirect_pc;
      @(posedge clock); #1;
      phase = P_IDLE;
      $display("op=%0d addr=%h rd=%0d wen=%0b wdata=%h exc=%0b cause=%0d rd_wen=%0b rd_data=%h redir=%0b rpc=%h",
               op, addr, rd, cap_wen, cap_wdata, cap_exc, cap_mcause, cap_rd_wen, cap_rd_data,
               cap_redir, cap_rpc);
   endtask

   int wen_before;

   initial begin
      in_valid = 1'b0; in_op = 3'd0; in_use_imm = 1'b0; in_uimm = 5'd0;
      in_rs1_data = 32'h0; in_csr_addr = 12'h0; in_rd = 5'd0; in_pc = 32'h0;
      out_ready = 1'b0;

      repeat (2) @(negedge clock);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_out_rd_data", out_rd_data, 32'h0);
      chk("reset_out_redirect_pc", out_redirect_pc, 32'h0);
      chk("reset_csr_waddr", {20'd0, csr_waddr}, 32'h0);
      reset = 1'b0;

      // CSRRW mtvec
      run_op(3'd0, 1'b0, 5'd1, 32'h8000_0100, 12'h305, 5'd5, 32'h8000_0000, 0);
      chk("rw_wen", {31'd0, cap_wen}, 32'd1);
      chk("rw_wdata", cap_wdata, 32'h8000_0100);
      chk("rw_rd_data", cap_rd_data, 32'h0);
      chk("rw_rd_wen", {31'd0, cap_rd_wen}, 32'd1);
      chk("rw_mtvec", mtvec_m, 32'h8000_0100);

      // CSRRS with rs1=x0: read only
      run_op(3'd1, 1'b0, 5'd0, 32'h0000_ffff, 12'h300, 5'd6, 32'h8000_0004, 0);
      chk("rs_x0_wen", {31'd0, cap_wen}, 32'd0);
      chk("rs_x0_rd_data", cap_rd_data, 32'h1800);

      // CSRRSI then CSRRCI on mstatus
      run_op(3'd1, 1'b1, 5'd8, 32'h0, 12'h300, 5'd7, 32'h8000_0008, 0);
      chk("rsi_wdata", cap_wdata, 32'h1808);
      run_op(3'd2, 1'b1, 5'd8, 32'hffff_ffff, 12'h300, 5'd0, 32'h8000_000c, 0);
      chk("rci_wdata", cap_wdata, 32'h1800);
      chk("rci_rd_data", cap_rd_data, 32'h1808);
      chk("rci_rd_wen_x0", {31'd0, cap_rd_wen}, 32'd0);

      // mtvec with mode bits set, then ECALL
      run_op(3'd0, 1'b0, 5'd2, 32'h8000_0103, 12'h305, 5'd0, 32'h8000_0010, 0);
      run_op(3'd3, 1'b0, 5'd0, 32'h0, 12'h000, 5'd7, 32'h8000_0040, 0);
      chk("ecall_exc", {31'd0, cap_exc}, 32'd1);
      chk("ecall_mepc", cap_mepc, 32'h8000_0040);
      chk("ecall_mcause", cap_mcause, 32'd11);
      chk("ecall_redirect", {31'd0, cap_redir}, 32'd1);
      chk("ecall_redirect_pc", cap_rpc, 32'h8000_0100);
      chk("ecall_rd_wen", {31'd0, cap_rd_wen}, 32'd0);

      // MRET
      run_op(3'd0, 1'b0, 5'd3, 32'h8000_0044, 12'h341, 5'd0, 32'h8000_0044, 0);
      run_op(3'd4, 1'b0, 5'd0, 32'h0, 12'h000, 5'd0, 32'h8000_0200, 0);
      chk("mret_wen", {31'd0, cap_wen}, 32'd0);
      chk("mret_exc", {31'd0, cap_exc}, 32'd0);
      chk("mret_redirect_pc", cap_rpc, 32'h8000_0044);

      // Illegal CSR address and illegal opcode
      run_op(3'd0, 1'b0, 5'd4, 32'h5, 12'h7c0, 5'd3, 32'h8000_0050, 0);
      chk("badaddr_exc", {31'd0, cap_exc}, 32'd1);
      chk("badaddr_mcause", cap_mcause, 32'd2);
      chk("badaddr_wen", {31'd0, cap_wen}, 32'd0);
      chk("badaddr_rd_wen", {31'd0, cap_rd_wen}, 32'd0);
      run_op(3'd6, 1'b0, 5'd1, 32'h1, 12'h300, 5'd2, 32'h8000_0060, 0);
      chk("badop_mcause", cap_mcause, 32'd2);
      chk("badop_mepc", mepc_m, 32'h8000_0060);

      // Backpressure: CSRRC on mcause with 5 stalled cycles
      wen_before = wen_count;
      run_op(3'd2, 1'b0, 5'd1, 32'h8, 12'h342, 5'd9, 32'h8000_0070, 5);
      chk("stall_wen_count", wen_count - wen_before, 32'd1);
      chk("stall_rd_data", cap_rd_data, 32'd2);

      // Reset while in EXEC: write strobe drops at once, result discarded
      wen_before = wen_count;
      @(negedge clock);
      exp_q = model(3'd0, 1'b0, 5'd1, 32'h0000_dead, 12'h300, 5'd4, 32'h8000_0080);
      in_op = 3'd0; in_use_imm = 1'b0; in_uimm = 5'd1; in_rs1_data = 32'h0000_dead;
      in_csr_addr = 12'h300; in_rd = 5'd4; in_pc = 32'h8000_0080; in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      phase    = P_EXEC;
      @(negedge clock); #1;
      chk("midreset_wen_before", {31'd0, csr_wen}, 32'd1);
      reset = 1'b1;
      phase = P_IDLE;
      #1;
      chk("midreset_wen_async", {31'd0, csr_wen}, 32'd0);
      chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("midreset_no_write", wen_count - wen_before, 32'd0);
      chk("midreset_mstatus", mstatus_m, 32'h1800);
      chk("midreset_out_rd_data", out_rd_data, 32'h0);
      $display("mid-op reset: wen=%0b out_valid=%0b mstatus=%h", csr_wen, out_valid, mstatus_m);

      // Recovery after reset
      run_op(3'd0, 1'b0, 5'd1, 32'h55, 12'h342, 5'd1, 32'h8000_0090, 0);
      chk("recover_rd_data", cap_rd_data, 32'd2);
      chk("recover_mcause", mcause_m, 32'h55);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
